// File: rtl/cache_miss_handler.sv
// Refill FSM for the set-associative L1: victim writeback, line fetch, word streaming, tag write, replacement update.
// MISS_WB_EN selects write-back mode (dirty victims go through WB); undefined gives a write-through build.
module cache_miss_handler #(
    parameter int SET_ASSOC  = 4,
    parameter int LINE_WORDS = 8,
    parameter int SET_BITS   = 7,
    parameter int ADDR_WIDTH = 32,
    localparam int OFFSET_BITS = $clog2(LINE_WORDS) + 2,
    localparam int TAG_WIDTH   = ADDR_WIDTH - SET_BITS - OFFSET_BITS,
    localparam int WAY_BITS    = $clog2(SET_ASSOC),
    localparam int WORD_BITS   = $clog2(LINE_WORDS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_req,
    input  logic [ADDR_WIDTH-1:0]          miss_addr,
    output logic                           miss_ready,
    input  logic [WAY_BITS-1:0]            repl_index,
    input  logic [SET_ASSOC-1:0]           dirty_mask,
    input  logic [SET_ASSOC*TAG_WIDTH-1:0] tag_flat,
    output logic                           wb_req,
    output logic [WAY_BITS-1:0]            wb_way,
    output logic [ADDR_WIDTH-1:0]          wb_addr,
    input  logic                           wb_ready,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_ack,
    input  logic                           mem_rvalid,
    input  logic [31:0]                    mem_rdata,
    output logic                           line_we,
    output logic [WAY_BITS-1:0]            line_way,
    output logic [SET_BITS-1:0]            line_set,
    output logic [WORD_BITS-1:0]           line_word,
    output logic [31:0]                    line_wdata,
    output logic                           tag_we,
    output logic [TAG_WIDTH-1:0]           tag_wdata,
    output logic [SET_ASSOC-1:0]           repl_access,
    output logic                           repl_update,
    output logic                           done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB     = 3'd1;
    localparam logic [2:0] S_REQ    = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [WAY_BITS-1:0]   victim;
    logic [WORD_BITS-1:0]  word_cnt;
    logic                  beat_vld;
    logic [WORD_BITS-1:0]  beat_word;
    logic [31:0]           beat_data;
    logic                  commit;
    logic [SET_BITS-1:0]   cur_set;

`ifdef MISS_WB_EN
    logic [TAG_WIDTH-1:0]  victim_tag;
    logic                  unused_lo;
    assign unused_lo = ^miss_addr[OFFSET_BITS-1:0];
`else
    logic                  unused_wb;
    assign unused_wb = ^{wb_ready, dirty_mask, tag_flat, miss_addr[OFFSET_BITS-1:0]};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            line_addr <= '0;
            victim    <= '0;
            word_cnt  <= '0;
            beat_vld  <= 1'b0;
            beat_word <= '0;
            beat_data <= '0;
`ifdef MISS_WB_EN
            victim_tag <= '0;
`endif
        end else begin
            beat_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (miss_req) begin
                        line_addr <= {miss_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        victim    <= repl_index;
`ifdef MISS_WB_EN
                        victim_tag <= tag_flat[int'(repl_index)*TAG_WIDTH +: TAG_WIDTH];
                        state      <= dirty_mask[repl_index] ? S_WB : S_REQ;
`else
                        state      <= S_REQ;
`endif
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        word_cnt <= '0;
                        state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    // Beats are registered so the data array write lands one cycle after the beat.
                    if (mem_rvalid) begin
                        beat_vld  <= 1'b1;
                        beat_word <= word_cnt;
                        beat_data <= mem_rdata;
                        word_cnt  <= word_cnt + 1'b1;
                        if (word_cnt == WORD_BITS'(LINE_WORDS - 1)) begin
                            state <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign cur_set    = line_addr[OFFSET_BITS +: SET_BITS];
    assign commit     = (state == S_COMMIT);

    assign miss_ready = (state == S_IDLE);

`ifdef MISS_WB_EN
    assign wb_req     = (state == S_WB);
    assign wb_way     = victim;
    assign wb_addr    = {victim_tag, cur_set, {OFFSET_BITS{1'b0}}};
`else
    assign wb_req     = 1'b0;
    assign wb_way     = '0;
    assign wb_addr    = '0;
`endif

    assign mem_req    = (state == S_REQ);
    assign mem_addr   = line_addr;

    assign line_we    = beat_vld;
    assign line_way   = victim;
    assign line_set   = cur_set;
    assign line_word  = beat_word;
    assign line_wdata = beat_data;

    // The final word write and the commit share a cycle; the tag is the fill's own tag field.
    assign tag_we      = commit;
    assign tag_wdata   = line_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign repl_update = commit;
    assign repl_access = commit ? (SET_ASSOC'(1) << victim) : '0;
    assign done        = commit;

endmodule
